// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX path (and the RX path that will follow).
// Holds the parity mode encoding, the TX FSM state type and a parity helper.
package uart_pkg;

  localparam int unsigned UART_PAR_NONE = 0;
  localparam int unsigned UART_PAR_ODD  = 1;
  localparam int unsigned UART_PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_tx_state_t;

  // Parity over the low nbits of data; odd mode inverts the XOR reduction.
  function automatic logic parity_bit(input logic [8:0] data, input int unsigned nbits,
                                      input int unsigned mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) x = x ^ data[i];
    end
    return (mode == UART_PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate tick generator.
// Ports:
//   clock - system clock
//   reset - synchronous active-high reset
//   clear - restart the count at zero on the next cycle
//   tick  - high while the count equals DIVISOR-1
module uart_baud_tick #(
  parameter int unsigned DIVISOR = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIVISOR - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || (cnt_q == CntMax)) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: pops words from a first-word-fall-through buffer and sends
// them LSB-first with optional parity and 1 or 2 stop bits.
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   tx_data             - head word of the TX buffer
//   tx_buf_not_empty    - buffer holds at least one word
//   tx_read_buf         - one-cycle pop strobe (combinational)
//   tx_pin_out          - serial line, idle high (registered)
//   tx_busy             - frame in progress (registered)
//   tx_done             - one-cycle pulse after the last stop-bit cycle (registered)
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = UART_PAR_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_buf_not_empty,
  output logic                 tx_read_buf,
  output logic                 tx_pin_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned DIVISOR = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BitCntW = 4;

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("uart_tx_frame: DIVISOR must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY > UART_PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_frame: unknown PARITY mode");
  end

  uart_tx_state_t       state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic                 par_q;
  logic                 pin_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 tick;

  // Pop only from IDLE and never while reset is being sampled.
  assign tx_read_buf = (state_q == StIdle) && tx_buf_not_empty && !reset;

  // The pop restarts the baud phase so every frame starts on a fresh count.
  uart_baud_tick #(
    .DIVISOR(DIVISOR)
  ) u_baud_tick (
    .clock(clock),
    .reset(reset),
    .clear(tx_read_buf),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      pin_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          pin_q <= 1'b1;
          if (tx_buf_not_empty) begin
            shreg_q   <= tx_data;
            par_q     <= parity_bit(9'(tx_data), DATA_BITS, PARITY);
            bit_cnt_q <= '0;
            pin_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            pin_q     <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (tick) begin
            if (bit_cnt_q == BitCntW'(DATA_BITS - 1)) begin
              bit_cnt_q <= '0;
              if (PARITY != UART_PAR_NONE) begin
                pin_q   <= par_q;
                state_q <= StParity;
              end else begin
                pin_q   <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              pin_q     <= shreg_q[0];
              shreg_q   <= shreg_q >> 1;
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            end
          end
        end
        StParity: begin
          if (tick) begin
            pin_q     <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= StStop;
          end
        end
        StStop: begin
          if (tick) begin
            if (bit_cnt_q == BitCntW'(STOP_BITS - 1)) begin
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= StIdle;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_pin_out = pin_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three instances (8N1/D4, 7E2/D3, 8O1/D5)
// share one clock; each test drives one instance while the others sit idle.
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic       clk;
  logic [2:0] rst;
  logic [2:0] ne;
  logic [8:0] dat [3];
  logic [2:0] rd, pin, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame #(
    .CLK_FREQ(400), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(UART_PAR_NONE), .STOP_BITS(1)
  ) u_dut0 (
    .clock(clk), .reset(rst[0]), .tx_data(dat[0][7:0]), .tx_buf_not_empty(ne[0]),
    .tx_read_buf(rd[0]), .tx_pin_out(pin[0]), .tx_busy(busy[0]), .tx_done(done[0])
  );

  uart_tx_frame #(
    .CLK_FREQ(300), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(UART_PAR_EVEN), .STOP_BITS(2)
  ) u_dut1 (
    .clock(clk), .reset(rst[1]), .tx_data(dat[1][6:0]), .tx_buf_not_empty(ne[1]),
    .tx_read_buf(rd[1]), .tx_pin_out(pin[1]), .tx_busy(busy[1]), .tx_done(done[1])
  );

  uart_tx_frame #(
    .CLK_FREQ(500), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(UART_PAR_ODD), .STOP_BITS(1)
  ) u_dut2 (
    .clock(clk), .reset(rst[2]), .tx_data(dat[2][7:0]), .tx_buf_not_empty(ne[2]),
    .tx_read_buf(rd[2]), .tx_pin_out(pin[2]), .tx_busy(busy[2]), .tx_done(done[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One frame on instance k: pop in cycle N, then checks every cycle up to N+F+2.
  // The expected line is start, word LSB-first, optional hand-computed parity, stops.
  task automatic send_frame(input int k, input logic [8:0] word, input int nbits,
                            input bit has_par, input logic exp_par, input int stops,
                            input int div, input int frame_len, input bit scramble);
    int   slot;
    logic exp_pin;
    @(negedge clk);
    ne[k]  = 1'b1;
    dat[k] = word;
    #1;
    check_eq($sformatf("k%0d pop", k), 32'(rd[k]), 32'd1);
    for (int c = 1; c <= frame_len; c++) begin
      @(negedge clk);
      if (scramble) begin
        ne[k]  = c[0];
        dat[k] = ~word;
      end else begin
        ne[k] = 1'b0;
      end
      #1;
      slot = (c - 1) / div;
      if (slot == 0)                         exp_pin = 1'b0;
      else if (slot <= nbits)                exp_pin = word[slot-1];
      else if (has_par && slot == nbits + 1) exp_pin = exp_par;
      else                                   exp_pin = 1'b1;
      check_eq($sformatf("k%0d w%0h pin c%0d", k, word, c), 32'(pin[k]), 32'(exp_pin));
      check_eq($sformatf("k%0d w%0h busy c%0d", k, word, c), 32'(busy[k]), 32'd1);
      check_eq($sformatf("k%0d w%0h done c%0d", k, word, c), 32'(done[k]), 32'd0);
      check_eq($sformatf("k%0d w%0h rd c%0d", k, word, c), 32'(rd[k]), 32'd0);
    end
    @(negedge clk);
    ne[k] = 1'b0;
    #1;
    check_eq($sformatf("k%0d w%0h done end", k, word), 32'(done[k]), 32'd1);
    check_eq($sformatf("k%0d w%0h busy end", k, word), 32'(busy[k]), 32'd0);
    check_eq($sformatf("k%0d w%0h pin end", k, word), 32'(pin[k]), 32'd1);
    @(negedge clk);
    #1;
    check_eq($sformatf("k%0d w%0h done after", k, word), 32'(done[k]), 32'd0);
  endtask

  // Three queued words on instance 0 (8N1, D=4, F=40).
  task automatic back_to_back();
    logic [7:0] words [3];
    logic       pin_log  [130];
    logic       done_log [130];
    int         pops     [3];
    int         np;
    int         nd;
    int         s;
    words = '{8'h01, 8'h02, 8'h03};
    np = 0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      ne[0]  = (np < 3);
      dat[0] = (np < 3) ? {1'b0, words[np]} : 9'h0;
      #1;
      pin_log[c]  = pin[0];
      done_log[c] = done[0];
      if (rd[0]) begin
        if (np < 3) pops[np] = c;
        np++;
      end
    end
    ne[0] = 1'b0;
    check_eq("b2b pop count", 32'(np), 32'd3);
    check_eq("b2b pop0", 32'(pops[0]), 32'd0);
    check_eq("b2b pop1", 32'(pops[1]), 32'd41);
    check_eq("b2b pop2", 32'(pops[2]), 32'd82);
    nd = 0;
    for (int c = 0; c < 130; c++) if (done_log[c]) nd++;
    check_eq("b2b done count", 32'(nd), 32'd3);
    for (int f = 0; f < 3; f++) begin
      s = 1 + 41 * f;
      check_eq($sformatf("b2b done f%0d", f), 32'(done_log[s + 40]), 32'd1);
      check_eq($sformatf("b2b start f%0d", f), 32'(pin_log[s]), 32'd0);
      check_eq($sformatf("b2b start end f%0d", f), 32'(pin_log[s + 3]), 32'd0);
      if (f > 0) check_eq($sformatf("b2b gap f%0d", f), 32'(pin_log[s - 1]), 32'd1);
      for (int i = 0; i < 8; i++)
        check_eq($sformatf("b2b f%0d bit%0d", f, i), 32'(pin_log[s + 4 + 4 * i + 1]),
                 32'(words[f][i]));
      check_eq($sformatf("b2b stop f%0d", f), 32'(pin_log[s + 36]), 32'd1);
    end
  endtask

  // Reset in cycle 18 (inside bit 3) of a frame on instance 0, buffer kept non-empty.
  task automatic reset_mid_frame();
    @(negedge clk);
    ne[0]  = 1'b1;
    dat[0] = 9'h0F0;
    #1;
    check_eq("rst pop", 32'(rd[0]), 32'd1);
    for (int c = 1; c <= 18; c++) @(negedge clk);
    rst[0] = 1'b1;
    #1;
    check_eq("rst rd during reset", 32'(rd[0]), 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    #1;
    check_eq("rst pin", 32'(pin[0]), 32'd1);
    check_eq("rst busy", 32'(busy[0]), 32'd0);
    check_eq("rst done", 32'(done[0]), 32'd0);
    check_eq("rst repop", 32'(rd[0]), 32'd1);
    // New frame popped in cycle 19: its done lands in cycle 60; nothing earlier.
    for (int c = 20; c <= 60; c++) begin
      @(negedge clk);
      ne[0] = 1'b0;
      #1;
      if (c == 20) check_eq("rst new start", 32'(pin[0]), 32'd0);
      check_eq($sformatf("rst done c%0d", c), 32'(done[0]), 32'(c == 60));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 3'b111;
    ne  = 3'b111;
    dat = '{9'h0AA, 9'h055, 9'h0AA};
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("k%0d reset rd", k), 32'(rd[k]), 32'd0);
      check_eq($sformatf("k%0d reset pin", k), 32'(pin[k]), 32'd1);
      check_eq($sformatf("k%0d reset busy", k), 32'(busy[k]), 32'd0);
      check_eq($sformatf("k%0d reset done", k), 32'(done[k]), 32'd0);
    end
    @(negedge clk);
    rst = 3'b000;
    ne  = 3'b000;
    repeat (2) @(negedge clk);

    // 8N1 D=4, 0xA5: F = 10*4 = 40.
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 4, 40, 1'b0);
    // 7E2 D=3, 0x13 (three ones): parity 1, F = 11*3 = 33.
    send_frame(1, 9'h013, 7, 1'b1, 1'b1, 2, 3, 33, 1'b0);
    // 8O1 D=5: 0xFF (eight ones) -> 1, 0xFE (seven ones) -> 0, F = 11*5 = 55.
    send_frame(2, 9'h0FF, 8, 1'b1, 1'b1, 1, 5, 55, 1'b0);
    send_frame(2, 9'h0FE, 8, 1'b1, 1'b0, 1, 5, 55, 1'b0);

    back_to_back();
    repeat (2) @(negedge clk);
    reset_mid_frame();
    repeat (2) @(negedge clk);

    // Inputs wiggled mid-frame must not pop or alter the word.
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 4, 40, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
